// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - shared PRBS31 constants and lock FSM state encoding
package prbs31_pkg;

    localparam int WORD_W = 32;
    localparam int TAP_A  = 28;
    localparam int TAP_B  = 31;

    // Only the last TAP_B bits of the previous word are ever referenced by the window check.
    localparam int HIST_W = TAP_B;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/prbs31_word_check.sv
// rtl/prbs31_word_check.sv - combinational PRBS31 recurrence check over one word plus history
module prbs31_word_check
    import prbs31_pkg::*;
(
    input  logic [HIST_W-1:0] history,
    input  logic [WORD_W-1:0] data_in,
    output logic              word_ok
);

    logic [WORD_W+HIST_W-1:0] window;
    logic [WORD_W-1:0]        mismatch;

    // window[HIST_W+i] is the new bit; its taps sit TAP_B and TAP_A bits earlier.
    always_comb begin
        window   = {data_in, history};
        mismatch = '0;
        for (int i = 0; i < WORD_W; i++) begin
            mismatch[i] = window[HIST_W + i]
                        ^ window[HIST_W + i - TAP_B]
                        ^ window[HIST_W + i - TAP_A];
        end
        word_ok = ~(|mismatch) && (|data_in);
    end

endmodule

// File: rtl/prbs31_lock_detector.sv
// rtl/prbs31_lock_detector.sv - PRBS31 self-synchronizing word lock detector with hysteresis
module prbs31_lock_detector
    import prbs31_pkg::*;
#(
    parameter int LOCK_GOOD  = 64,
    parameter int UNLOCK_BAD = 4,
    parameter int LOSS_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pulse,
    input  logic              data_valid,
    input  logic [WORD_W-1:0] DataIn,
    output logic [WORD_W-1:0] DataOut,
    output logic              DataOut_valid,
    output logic              locked,
    output logic [1:0]        state,
    output logic [31:0]       bad_word_count,
    output logic [LOSS_W-1:0] lock_loss_count
);

    localparam logic [15:0] LOCK_GOOD_W  = 16'(LOCK_GOOD);
    localparam logic [7:0]  UNLOCK_BAD_W = 8'(UNLOCK_BAD);

    lock_state_e        state_q, state_d;
    logic [15:0]        good_run_q, good_run_d;
    logic [7:0]         bad_run_q, bad_run_d;
    logic [HIST_W-1:0]  prev_word_q, prev_word_d;
    logic               prev_ok_q, prev_ok_d;
    logic [WORD_W-1:0]  data_out_q, data_out_d;
    logic               data_out_valid_q, data_out_valid_d;
    logic [31:0]        bad_word_count_q, bad_word_count_d;
    logic [LOSS_W-1:0]  lock_loss_count_q, lock_loss_count_d;

    logic word_ok;
    logic evaluate;
    logic good_word;
    logic bad_word;
    logic reach_lock;
    logic reach_unlock;
    logic enter_hunt;
    logic bad_inc;
    logic loss_inc;

    prbs31_word_check u_word_check (
        .history (prev_word_q),
        .data_in (DataIn),
        .word_ok (word_ok)
    );

    // A valid word is only judged once a predecessor has been primed into prev_word.
    assign evaluate     = data_valid && prev_ok_q;
    assign good_word    = evaluate && word_ok;
    assign bad_word     = evaluate && !word_ok;
    assign reach_lock   = (good_run_q + 16'd1) == LOCK_GOOD_W;
    assign reach_unlock = (bad_run_q + 8'd1) == UNLOCK_BAD_W;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= HUNT;
            good_run_q        <= '0;
            bad_run_q         <= '0;
            prev_word_q       <= '0;
            prev_ok_q         <= 1'b0;
            data_out_q        <= '0;
            data_out_valid_q  <= 1'b0;
            bad_word_count_q  <= '0;
            lock_loss_count_q <= '0;
        end else begin
            state_q           <= state_d;
            good_run_q        <= good_run_d;
            bad_run_q         <= bad_run_d;
            prev_word_q       <= prev_word_d;
            prev_ok_q         <= prev_ok_d;
            data_out_q        <= data_out_d;
            data_out_valid_q  <= data_out_valid_d;
            bad_word_count_q  <= bad_word_count_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (good_word) begin
                    state_d = reach_lock ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (good_word && reach_lock) begin
                    state_d = LOCKED;
                end else if (bad_word) begin
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (bad_word && reach_unlock) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign enter_hunt = (state_q != HUNT) && (state_d == HUNT);
    assign bad_inc    = bad_word && (state_q != HUNT);
    assign loss_inc   = (state_q == LOCKED) && (state_d == HUNT);

    always_comb begin
        prev_word_d       = prev_word_q;
        prev_ok_d         = prev_ok_q;
        good_run_d        = good_run_q;
        bad_run_d         = bad_run_q;
        bad_word_count_d  = bad_word_count_q;
        lock_loss_count_d = lock_loss_count_q;
        data_out_d        = DataIn;
        data_out_valid_d  = data_valid;

        if (data_valid) begin
            prev_word_d = DataIn[WORD_W-1:WORD_W-HIST_W];
            prev_ok_d   = 1'b1;
        end

        if (good_word && (state_q != LOCKED)) begin
            good_run_d = good_run_q + 16'd1;
        end
        if (state_q == LOCKED) begin
            if (good_word) begin
                bad_run_d = '0;
            end else if (bad_word) begin
                bad_run_d = bad_run_q + 8'd1;
            end
        end
        if (state_d == LOCKED && state_q != LOCKED) begin
            bad_run_d = '0;
        end

        // Re-entering HUNT discards the history so the next valid word primes again.
        if (enter_hunt) begin
            prev_ok_d  = 1'b0;
            good_run_d = '0;
            bad_run_d  = '0;
        end

        if (pulse) begin
            bad_word_count_d  = '0;
            lock_loss_count_d = '0;
        end else begin
            if (bad_inc && !(&bad_word_count_q)) begin
                bad_word_count_d = bad_word_count_q + 32'd1;
            end
            if (loss_inc && !(&lock_loss_count_q)) begin
                lock_loss_count_d = lock_loss_count_q + {{(LOSS_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        locked          = (state_q == LOCKED);
        state           = state_q;
        DataOut         = data_out_q;
        DataOut_valid   = data_out_valid_q;
        bad_word_count  = bad_word_count_q;
        lock_loss_count = lock_loss_count_q;
    end

endmodule

// File: doc/prbs31_lock_detector.md
Name: prbs31_lock_detector

Overview:
- Sits directly upstream of the PRBS31 error-bit checker on the KC705 receive path, fed by the 32-bit deserialized word stream.
- Self-synchronizes to PRBS31 (x^31 + x^28 + 1) with no seed exchange and declares word-level lock using a hysteresis FSM.
- Forwards the data stream, registered and aligned with the lock flag, so the checker's error counter is only trusted while locked.
- Keeps saturating bad-word and lock-loss statistics for the SEU test readout.

Parameters:
- LOCK_GOOD, 64: consecutive good words needed to enter LOCKED (1..65535).
- UNLOCK_BAD, 4: consecutive bad words in LOCKED that force HUNT (1..255).
- LOSS_W, 16: width of lock_loss_count.

Ports:
- clock  in  1  data clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- pulse  in  1  synchronous counter clear (bad_word_count, lock_loss_count); does not affect the FSM.
- data_valid  in  1  DataIn qualifier.
- DataIn  in  32  received word; bit 0 is earliest in time, bit 31 latest.
- DataOut  out  32  DataIn delayed 1 cycle.
- DataOut_valid  out  1  data_valid delayed 1 cycle.
- locked  out  1  high while the FSM is in LOCKED.
- state  out  2  FSM state: 0=HUNT, 1=VERIFY, 2=LOCKED.
- bad_word_count  out  32  saturating count of bad words evaluated in VERIFY or LOCKED.
- lock_loss_count  out  LOSS_W  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Reset values:
  - all outputs 0, state=HUNT.
  - prev_word=0, prev_ok=0, run counters 0.
- Interface: one clock, synchronous active-high reset; clock and reset named exactly as above.
- Window: on each valid cycle form w[63:0] = {DataIn, prev_word}.
  - word_ok = (for all i in 0..31: w[32+i] == w[1+i] ^ w[4+i]) AND (DataIn != 0).
  - The all-zero word is always bad; PRBS31 zero runs are at most 30 bits.
- Priming:
  - The first valid word after reset or after entering HUNT is not evaluated; it only loads prev_word and sets prev_ok.
  - prev_word <= DataIn on every valid cycle.
- data_valid=0 cycles freeze prev_word, runs, FSM and counters; gaps never break a run.
- FSM transitions occur on valid, evaluated words only:
  - HUNT:
    - good -> VERIFY with good_run=1.
    - bad stays in HUNT.
  - VERIFY:
    - good -> good_run+1; when good_run reaches LOCK_GOOD, go to LOCKED with bad_run=0.
    - bad -> HUNT, good_run=0, bad_word_count+1.
  - LOCKED:
    - good -> bad_run=0.
    - bad -> bad_run+1 and bad_word_count+1; when bad_run reaches UNLOCK_BAD, go to HUNT, lock_loss_count+1, prev_ok=0.
- Latency:
  - locked and state reflect the word evaluated on the previous edge.
  - DataOut/DataOut_valid have the same 1-cycle latency, so locked is aligned with the word that caused it.
- Counters:
  - Saturate at all-ones, never wrap.
  - pulse clears both counters; if pulse and an increment occur in the same cycle, the result is 0.
  - reset overrides pulse.
- Reset mid-operation: next cycle is exactly the reset state, and the next valid word primes.

Decomposition:
- Shared package prbs31_pkg:
  - PRBS31 taps (TAP_A=28, TAP_B=31).
  - word width 32.
  - state encodings HUNT/VERIFY/LOCKED.
- One natural sub-module, prbs31_word_check: combinational window check producing word_ok, reusable by the generator and checker.

Test Plan:
- Reset check: assert reset 3 cycles with DataIn random -> all outputs 0, state=0.
- Clean lock: 70 consecutive valid PRBS31 words.
  - state=1 one cycle after word 2.
  - locked=1 one cycle after word 65.
  - bad_word_count=0.
- Stalled lock: same stream with data_valid=0 every other cycle -> locked after word 65, identical counts.
- Single-bit flip while locked: flip bit 10 of one word.
  - Exactly 2 bad words (that word and the next), so bad_word_count=2.
  - locked stays 1, lock_loss_count=0.
- Lock loss: while locked, 4 all-zero words.
  - locked=0 one cycle after the 4th, state=0.
  - lock_loss_count=1, bad_word_count=4.
  - Resuming a clean PRBS stream relocks after 1 prime word + 64 good words.
- Clear/saturation: pulse during a bad word -> counters 0 next cycle. Force bad_word_count to 0xFFFFFFFF, then a bad word -> it holds 0xFFFFFFFF.
